pft_ctrl: RTL and testbench
===========================

# pft_ctrl

Sequencing controller for the 32-bank point-feature-table BRAM (`PFT_bram`). It works in two directions:
- **Fill:** it accepts per-bank write requests and appends each row at that bank's fill pointer.
- **Sweep:** on command it reads every filled row of the selected banks in lockstep, for the PE array (normal mode) or for a single centroid bank (centroid mode).

It drives the BRAM's `PFT_raddr`/`write`/`PFT_waddr`/`din`/`valid`/`is_centroid` inputs. It also emits a `dout_valid` strobe aligned to the BRAM's `dout`.

## Interface
Parameters:
- `PFT_addr_width`, 5: row address width; bank depth is 2^`PFT_addr_width` = 32.
- `PFT_data_width`, 8: element width.
- `PE_COL`, 16: elements per row.
- `PFT_bank`, 32: number of banks.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `wr_valid`, in, 1: write request.
- `wr_ready`, out, 1: write accepted when both `wr_valid` and `wr_ready` are high.
- `wr_bank`, in, 5: target bank.
- `wr_data`, in, `PFT_data_width*PE_COL`: row data.
- `clear`, in, 1: zero all fill counts; aborts any sweep.
- `rd_start`, in, 1: start a sweep (pulse).
- `rd_mask`, in, `PFT_bank`: banks to read; sampled on `rd_start`.
- `rd_centroid`, in, 1: centroid mode; sampled on `rd_start`.
- `rd_busy`, out, 1: sweep in progress.
- `rd_done`, out, 1: one-cycle pulse at sweep end.
- `dout_valid`, out, 1: BRAM `dout` holds sweep row `dout_idx`.
- `dout_idx`, out, `PFT_addr_width`: row index of the current `dout`.
- `PFT_raddr`, out, `PFT_addr_width*PFT_bank`: per-bank read address.
- `write`, out, `PFT_bank`: one-hot write enable.
- `PFT_waddr`, out, `PFT_addr_width`: write address.
- `din`, out, `PFT_data_width*PE_COL`: write data.
- `valid`, out, `PFT_bank`: per-bank valid mask to the BRAM.
- `is_centroid`, out, 1: selects the centroid output path.

## Operation
- **Fill counters:** each bank has a count `cnt[b]` in the range 0..32, 6 bits wide.
- **Write acceptance:** `wr_ready` = !`rd_busy` && (`cnt[wr_bank]` != 32). This is combinational from `wr_bank`.
- **Accepted write:** `write` is one-hot at `wr_bank`, `PFT_waddr` = `cnt[wr_bank]`, and `din` = `wr_data`. All three are driven combinationally in the acceptance cycle, and the count increments at the edge.
- **Full bank:** a write to a bank at count 32 is not accepted; the count does not wrap. `write` is zero when no write is accepted.
- **FSM states:** IDLE, SWEEP, DRAIN.
- **IDLE to SWEEP:** on `rd_start`, latch the mask. In centroid mode, reduce the mask to its lowest set bit.
- **Sweep length:** L = max `cnt[b]` over masked banks.
- **Empty sweep:** if L = 0 (including an empty mask), go straight to DRAIN with no `dout_valid`.
- **SWEEP:** row index k runs 0..L-1, one per cycle, and `PFT_raddr[b]` = k for all banks. After k = L-1, go to DRAIN.
- **DRAIN:** lasts one cycle, then IDLE.
- **Normal-mode valid:** `valid[b]` = mask[b] && (k_prev < `cnt[b]`), registered. It is presented one cycle after the address that produced the data, so the BRAM masks short banks with 0x80.
- **Centroid-mode valid:** `valid` is the one-hot mask, presented in the same cycle as the address, because the BRAM's bank encoder is registered. `is_centroid` = 1 from SWEEP entry through DRAIN.
- **Writes during a sweep:** blocked while `rd_busy`, so the latched counts stay consistent.
- **Ignored `rd_start`:** ignored while `rd_busy`.
- **`clear`:**
  - Clears all counts and forces IDLE.
  - Suppresses `rd_done` and drops the pending `dout_valid`.
  - Has priority over a simultaneous write or `rd_start`.

## Timing
- **Reset (async):**
  - Internal: all `cnt` = 0, state IDLE.
  - Control outputs low: `rd_busy`, `rd_done`, `dout_valid`, `is_centroid`, `write`, `valid`.
  - Address and index outputs: `dout_idx` = 0, `PFT_raddr` = 0.
- **Read latency:**
  - Address k issued in cycle T; `dout_valid` = 1 with `dout_idx` = k in cycle T+1 (BRAM latency 1).
  - `rd_done` is asserted in the DRAIN cycle, coincident with the last `dout_valid`. For L = 0 it comes 1 cycle after `rd_start`.
- **`rd_busy`:**
  - High from the cycle after `rd_start` through DRAIN inclusive.
  - A new `rd_start` is accepted the cycle after DRAIN.
- **Full sweep duration:** a sweep of L rows occupies L + 1 busy cycles.
- **Write timing:** combinational to BRAM port A.
- **Back-to-back writes:** one write per cycle; consecutive writes to the same bank get consecutive addresses.

## Structure
- **Package `pft_pkg`:**
  - FSM state enum: IDLE, SWEEP, DRAIN.
  - Depth constant, 32.
  - Count width, 6.
  - Pad constant 0x80.
- **Sub-module `pft_fill_tracker`:**
  - Holds the 32 counters with increment and clear.
  - Provides the full/ready lookup.
  - Reduces the masked max via a registered-free compare tree.
- **Top level:** the FSM, valid alignment, and BRAM port muxing.

## Test plan
- **Fill:** write 3 rows to bank 0 and 1 row to bank 5 → `PFT_waddr` sequence 0,1,2 (bank 0) then 0 (bank 5); `write` = 0x1, 0x1, 0x1, 0x20.
- **Normal sweep:** mask 0x21 → L = 3; `dout_valid` for 3 cycles with `dout_idx` 0,1,2.
  - `valid` = 0x21, 0x01, 0x01 on the data cycles.
  - `rd_done` on the 3rd cycle.
- **Centroid sweep:** mask 0x30, centroid, `cnt[4]` = 2 → mask reduced to 0x10; `valid` = 0x10 concurrent with addresses 0,1; `is_centroid` = 1; 2 `dout_valid` cycles.
- **Full bank:** 33 writes to bank 7 → `wr_ready` = 0 on the 33rd; `cnt[7]` stays 32. A sweep of mask 0x80 then gives `dout_idx` 0..31.
- **Empty and blocked cases:**
  - Empty mask `rd_start` → `rd_done` next cycle, no `dout_valid`.
  - A `wr_valid` during a sweep sees `wr_ready` = 0.
- **`clear` mid-sweep:** `clear` at k = 1 → IDLE next cycle, no `rd_done`, all counts 0.
- **`rst` mid-sweep:** async `rst` mid-sweep → outputs return to reset values immediately.

Source files
------------

// File: rtl/pft_pkg.sv
// Shared definitions for the point-feature-table controller slice.
//   pft_state_t : sweep sequencer states
//   PFT_DEPTH   : rows per bank
//   PFT_CNT_W   : fill-count width (holds 0..PFT_DEPTH)
//   PFT_PAD     : element value the BRAM substitutes for invalid banks
package pft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } pft_state_t;

  localparam int unsigned PFT_DEPTH = 32;
  localparam int unsigned PFT_CNT_W = 6;
  localparam logic [7:0]  PFT_PAD   = 8'h80;

endpackage

// File: rtl/pft_fill_tracker.sv
// Per-bank fill counters for the point-feature table.
//   clk, rst        : clock, async active-high reset
//   clear           : zero every count
//   inc, inc_bank   : append one row to inc_bank
//   query_bank      : bank looked up for the write path
//   query_addr      : current fill pointer of query_bank (next free row)
//   query_full      : query_bank holds a full bank of rows
//   sel_mask        : banks taking part in the max reduction
//   max_cnt         : largest count among sel_mask banks (0 if none)
//   row_k           : row index under test
//   row_live        : per bank, row_k is a filled row
module pft_fill_tracker #(
  parameter int unsigned PFT_addr_width = 5,
  parameter int unsigned PFT_bank       = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            inc,
  input  logic [$clog2(PFT_bank)-1:0]     inc_bank,
  input  logic [$clog2(PFT_bank)-1:0]     query_bank,
  output logic [PFT_addr_width-1:0]       query_addr,
  output logic                            query_full,
  input  logic [PFT_bank-1:0]             sel_mask,
  output logic [PFT_addr_width:0]         max_cnt,
  input  logic [PFT_addr_width-1:0]       row_k,
  output logic [PFT_bank-1:0]             row_live
);

  localparam int unsigned CW = PFT_addr_width + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {PFT_addr_width{1'b0}}};

  logic [CW-1:0] cnt [PFT_bank];
  logic [CW-1:0] q_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PFT_bank; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < PFT_bank; i++) cnt[i] <= '0;
    end else if (inc && (cnt[inc_bank] != DEPTH)) begin
      cnt[inc_bank] <= cnt[inc_bank] + 1'b1;
    end
  end

  always_comb begin
    q_cnt      = cnt[query_bank];
    query_addr = q_cnt[PFT_addr_width-1:0];
    query_full = (q_cnt == DEPTH);
  end

  // Purely combinational max over the selected banks; feeds the sweep
  // length latched on rd_start.
  always_comb begin
    max_cnt = '0;
    for (int unsigned i = 0; i < PFT_bank; i++) begin
      if (sel_mask[i] && (cnt[i] > max_cnt)) max_cnt = cnt[i];
    end
  end

  always_comb begin
    row_live = '0;
    for (int unsigned i = 0; i < PFT_bank; i++) begin
      row_live[i] = (cnt[i] > {1'b0, row_k});
    end
  end

endmodule

// File: rtl/pft_ctrl.sv
// Sequencing controller for the 32-bank point-feature-table BRAM.
// Fills banks row by row from a write handshake and sweeps the filled rows
// of selected banks in lockstep (normal or single-bank centroid mode).
//   clk, rst               : clock, async active-high reset
//   wr_valid/wr_ready      : row write handshake; wr_bank, wr_data payload
//   clear                  : zero all fill counts, abort any sweep
//   rd_start               : start sweep; rd_mask, rd_centroid sampled here
//   rd_busy, rd_done       : sweep in progress / one-cycle end pulse
//   dout_valid, dout_idx   : BRAM dout holds sweep row dout_idx
//   PFT_raddr              : per-bank read address (all banks equal)
//   write, PFT_waddr, din  : BRAM port A write (combinational)
//   valid, is_centroid     : BRAM bank-valid mask and centroid path select
module pft_ctrl
  import pft_pkg::*;
#(
  parameter int unsigned PFT_addr_width = 5,
  parameter int unsigned PFT_data_width = 8,
  parameter int unsigned PE_COL         = 16,
  parameter int unsigned PFT_bank       = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [$clog2(PFT_bank)-1:0]         wr_bank,
  input  logic [PFT_data_width*PE_COL-1:0]    wr_data,
  input  logic                                clear,
  input  logic                                rd_start,
  input  logic [PFT_bank-1:0]                 rd_mask,
  input  logic                                rd_centroid,
  output logic                                rd_busy,
  output logic                                rd_done,
  output logic                                dout_valid,
  output logic [PFT_addr_width-1:0]           dout_idx,
  output logic [PFT_addr_width*PFT_bank-1:0]  PFT_raddr,
  output logic [PFT_bank-1:0]                 write,
  output logic [PFT_addr_width-1:0]           PFT_waddr,
  output logic [PFT_data_width*PE_COL-1:0]    din,
  output logic [PFT_bank-1:0]                 valid,
  output logic                                is_centroid
);

  localparam int unsigned CW = PFT_addr_width + 1;

  pft_state_t                state;
  logic [PFT_addr_width-1:0] k;
  logic [CW-1:0]             sweep_len;
  logic [PFT_bank-1:0]       lat_mask;
  logic [PFT_bank-1:0]       sel_mask;
  logic [PFT_bank-1:0]       row_live;
  logic [CW-1:0]             max_cnt;
  logic                      bank_full;
  logic                      wr_accept;
  logic                      found;

  // Centroid mode keeps only the lowest requested bank.
  always_comb begin
    sel_mask = rd_mask;
    found    = 1'b0;
    if (rd_centroid) begin
      sel_mask = '0;
      for (int unsigned i = 0; i < PFT_bank; i++) begin
        if (rd_mask[i] && !found) begin
          sel_mask[i] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  pft_fill_tracker #(
    .PFT_addr_width (PFT_addr_width),
    .PFT_bank       (PFT_bank)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .inc        (wr_accept),
    .inc_bank   (wr_bank),
    .query_bank (wr_bank),
    .query_addr (PFT_waddr),
    .query_full (bank_full),
    .sel_mask   (sel_mask),
    .max_cnt    (max_cnt),
    .row_k      (k),
    .row_live   (row_live)
  );

  assign rd_busy   = (state != IDLE);
  assign wr_ready  = !rd_busy && !bank_full;
  // clear wins over a coincident write: nothing reaches the BRAM.
  assign wr_accept = wr_valid && wr_ready && !clear;
  assign din       = wr_data;
  assign PFT_raddr = {PFT_bank{k}};

  always_comb begin
    write = '0;
    if (wr_accept) write[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      sweep_len   <= '0;
      lat_mask    <= '0;
      rd_done     <= 1'b0;
      dout_valid  <= 1'b0;
      dout_idx    <= '0;
      valid       <= '0;
      is_centroid <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      k           <= '0;
      rd_done     <= 1'b0;
      dout_valid  <= 1'b0;
      valid       <= '0;
      is_centroid <= 1'b0;
    end else begin
      rd_done    <= 1'b0;
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start) begin
            lat_mask    <= sel_mask;
            sweep_len   <= max_cnt;
            k           <= '0;
            is_centroid <= rd_centroid;
            if (max_cnt == '0) begin
              state   <= DRAIN;
              rd_done <= 1'b1;
              valid   <= '0;
            end else begin
              state <= SWEEP;
              // Centroid valid rides with the address (registered encoder
              // in the BRAM); normal valid follows the data one cycle later.
              valid <= rd_centroid ? sel_mask : '0;
            end
          end
        end
        SWEEP: begin
          dout_valid <= 1'b1;
          dout_idx   <= k;
          if (!is_centroid) valid <= lat_mask & row_live;
          if ({1'b0, k} == sweep_len - 1'b1) begin
            state   <= DRAIN;
            rd_done <= 1'b1;
            if (is_centroid) valid <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          state       <= IDLE;
          k           <= '0;
          valid       <= '0;
          is_centroid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pft_ctrl.sv
module tb_pft_ctrl;
  import pft_pkg::*;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int PC = 16;
  localparam int NB = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [4:0]        wr_bank;
  logic [DW*PC-1:0]  wr_data;
  logic              clear;
  logic              rd_start;
  logic [NB-1:0]     rd_mask;
  logic              rd_centroid;
  logic              rd_busy;
  logic              rd_done;
  logic              dout_valid;
  logic [AW-1:0]     dout_idx;
  logic [AW*NB-1:0]  PFT_raddr;
  logic [NB-1:0]     write;
  logic [AW-1:0]     PFT_waddr;
  logic [DW*PC-1:0]  din;
  logic [NB-1:0]     valid;
  logic              is_centroid;

  pft_ctrl #(
    .PFT_addr_width (AW),
    .PFT_data_width (DW),
    .PE_COL         (PC),
    .PFT_bank       (NB)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_bank(wr_bank), .wr_data(wr_data), .clear(clear), .rd_start(rd_start),
    .rd_mask(rd_mask), .rd_centroid(rd_centroid), .rd_busy(rd_busy),
    .rd_done(rd_done), .dout_valid(dout_valid), .dout_idx(dout_idx),
    .PFT_raddr(PFT_raddr), .write(write), .PFT_waddr(PFT_waddr), .din(din),
    .valid(valid), .is_centroid(is_centroid)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cnt_m[NB];

  typedef struct {
    logic [4:0]  bank;
    logic [31:0] exp_write;
    logic [4:0]  exp_waddr;
  } fill_vec_t;

  typedef struct {
    logic        busy;
    logic        done;
    logic        dv;
    logic [4:0]  idx;
    logic [31:0] valid;
  } sweep_vec_t;

  fill_vec_t  fill_tab[4];
  sweep_vec_t sweep_tab[5];

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] rep_addr(input int k);
    logic [159:0] e = '0;
    for (int b = 0; b < NB; b++) e[b*AW +: AW] = 5'(k);
    return e;
  endfunction

  function automatic logic [31:0] eff_mask(input logic [31:0] m, input logic cent);
    return cent ? (m & (~m + 32'd1)) : m;
  endfunction

  function automatic int sweep_rows(input logic [31:0] m);
    int l = 0;
    for (int b = 0; b < NB; b++) if (m[b] && cnt_m[b] > l) l = cnt_m[b];
    return l;
  endfunction

  function automatic logic [DW*PC-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_write(input int bank);
    logic        acc;
    logic [31:0] ew;
    wr_valid = 1'b1;
    wr_bank  = 5'(bank);
    wr_data  = rnd_row();
    @(negedge clk);
    acc = (cnt_m[bank] != int'(PFT_DEPTH));
    ew  = acc ? (32'd1 << bank) : 32'd0;
    chk("wr_ready", 160'(wr_ready), 160'(acc));
    chk("write", 160'(write), 160'(ew));
    if (acc) begin
      chk("waddr", 160'(PFT_waddr), 160'(cnt_m[bank]));
      chk("din", 160'(din), 160'(wr_data));
    end
    tick();
    if (acc) cnt_m[bank]++;
    wr_valid = 1'b0;
  endtask

  task automatic do_sweep(input logic [31:0] mask, input logic cent);
    logic [31:0] m, ev;
    int l, last;
    m    = eff_mask(mask, cent);
    l    = sweep_rows(m);
    last = l + 1;
    rd_start    = 1'b1;
    rd_mask     = mask;
    rd_centroid = cent;
    @(negedge clk);
    chk("sw_idle_busy", 160'(rd_busy), 160'(1'b0));
    tick();
    for (int c = 1; c <= last; c++) begin
      // noise that a busy controller must ignore
      rd_start    = 1'($urandom_range(0, 1));
      rd_mask     = $urandom;
      rd_centroid = 1'($urandom_range(0, 1));
      wr_valid    = 1'b1;
      wr_bank     = 5'($urandom_range(0, NB - 1));
      @(negedge clk);
      chk("sw_busy", 160'(rd_busy), 160'(1'b1));
      chk("sw_done", 160'(rd_done), 160'(c == last));
      chk("sw_dv", 160'(dout_valid), 160'(c >= 2));
      if (c >= 2) chk("sw_idx", 160'(dout_idx), 160'(c - 2));
      chk("sw_isc", 160'(is_centroid), 160'(cent));
      if (c <= l) chk("sw_raddr", 160'(PFT_raddr), rep_addr(c - 1));
      ev = '0;
      if (cent) begin
        if (c <= l) ev = m;
      end else if (c >= 2) begin
        for (int b = 0; b < NB; b++) ev[b] = m[b] && (cnt_m[b] > c - 2);
      end
      chk("sw_valid", 160'(valid), 160'(ev));
      chk("sw_wr_ready", 160'(wr_ready), 160'(1'b0));
      chk("sw_write", 160'(write), 160'(32'd0));
      tick();
    end
    rd_start = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("sw_end_busy", 160'(rd_busy), 160'(1'b0));
    chk("sw_end_dv", 160'(dout_valid), 160'(1'b0));
    chk("sw_end_valid", 160'(valid), 160'(32'd0));
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_bank = '0; wr_data = '0; clear = 1'b0;
    rd_start = 1'b0; rd_mask = '0; rd_centroid = 1'b0;
    for (int b = 0; b < NB; b++) cnt_m[b] = 0;

    fill_tab[0] = '{5'd0, 32'h0000_0001, 5'd0};
    fill_tab[1] = '{5'd0, 32'h0000_0001, 5'd1};
    fill_tab[2] = '{5'd0, 32'h0000_0001, 5'd2};
    fill_tab[3] = '{5'd5, 32'h0000_0020, 5'd0};
    sweep_tab[0] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h00};
    sweep_tab[1] = '{1'b1, 1'b0, 1'b1, 5'd0, 32'h21};
    sweep_tab[2] = '{1'b1, 1'b0, 1'b1, 5'd1, 32'h01};
    sweep_tab[3] = '{1'b1, 1'b1, 1'b1, 5'd2, 32'h01};
    sweep_tab[4] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h00};

    // reset state
    @(negedge clk);
    chk("rst_busy", 160'(rd_busy), 160'(1'b0));
    chk("rst_done", 160'(rd_done), 160'(1'b0));
    chk("rst_dv", 160'(dout_valid), 160'(1'b0));
    chk("rst_isc", 160'(is_centroid), 160'(1'b0));
    chk("rst_valid", 160'(valid), 160'(32'd0));
    chk("rst_write", 160'(write), 160'(32'd0));
    chk("rst_idx", 160'(dout_idx), 160'(5'd0));
    chk("rst_raddr", 160'(PFT_raddr), 160'(0));
    rst = 1'b0;
    tick();

    // fill: bank 0 x3, bank 5 x1
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_bank  = fill_tab[i].bank;
      wr_data  = rnd_row();
      @(negedge clk);
      chk("fill_ready", 160'(wr_ready), 160'(1'b1));
      chk("fill_write", 160'(write), 160'(fill_tab[i].exp_write));
      chk("fill_waddr", 160'(PFT_waddr), 160'(fill_tab[i].exp_waddr));
      chk("fill_din", 160'(din), 160'(wr_data));
      tick();
      cnt_m[fill_tab[i].bank]++;
    end
    wr_valid = 1'b0;

    // normal sweep of mask 0x21 against fixed expectations
    rd_start = 1'b1; rd_mask = 32'h21; rd_centroid = 1'b0;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("tab_busy", 160'(rd_busy), 160'(sweep_tab[i].busy));
      chk("tab_done", 160'(rd_done), 160'(sweep_tab[i].done));
      chk("tab_dv", 160'(dout_valid), 160'(sweep_tab[i].dv));
      if (sweep_tab[i].dv) chk("tab_idx", 160'(dout_idx), 160'(sweep_tab[i].idx));
      chk("tab_valid", 160'(valid), 160'(sweep_tab[i].valid));
      tick();
    end

    // centroid sweep: 0x30 reduces to bank 4 with 2 rows
    do_write(4);
    do_write(4);
    do_sweep(32'h30, 1'b1);

    // full bank: 33rd write refused, sweep returns 32 rows
    for (int i = 0; i < 33; i++) do_write(7);
    do_sweep(32'h80, 1'b0);

    // clear at k = 1
    rd_start = 1'b1; rd_mask = 32'h80; rd_centroid = 1'b0;
    tick();
    rd_start = 1'b0;
    tick();
    @(negedge clk);
    chk("clr_k", 160'(PFT_raddr[4:0]), 160'(5'd1));
    chk("clr_dv_before", 160'(dout_valid), 160'(1'b1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_busy", 160'(rd_busy), 160'(1'b0));
    chk("clr_dv", 160'(dout_valid), 160'(1'b0));
    chk("clr_done", 160'(rd_done), 160'(1'b0));
    chk("clr_isc", 160'(is_centroid), 160'(1'b0));
    tick();
    @(negedge clk);
    chk("clr_done_late", 160'(rd_done), 160'(1'b0));
    tick();
    for (int b = 0; b < NB; b++) cnt_m[b] = 0;

    // clear beats a coincident write and rd_start
    do_write(2);
    clear = 1'b1; wr_valid = 1'b1; wr_bank = 5'd2; rd_start = 1'b1; rd_mask = '1;
    tick();
    clear = 1'b0; wr_valid = 1'b0; rd_start = 1'b0;
    @(negedge clk);
    chk("clr_start_busy", 160'(rd_busy), 160'(1'b0));
    tick();
    for (int b = 0; b < NB; b++) cnt_m[b] = 0;

    // empty sweeps, then fresh fills start at row 0
    do_sweep('1, 1'b0);
    do_sweep(32'h0, 1'b1);
    do_write(2);
    do_write(7);

    // randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 13) begin
        do_write($urandom_range(0, 3));
      end else if (r < 19) begin
        do_sweep($urandom & 32'h0000_001f, 1'($urandom_range(0, 1)));
      end else begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int b = 0; b < NB; b++) cnt_m[b] = 0;
      end
    end

    // async reset mid-sweep
    do_write(1); do_write(1); do_write(1);
    rd_start = 1'b1; rd_mask = 32'h2; rd_centroid = 1'b0;
    tick();
    rd_start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 160'(rd_busy), 160'(1'b0));
    chk("arst_done", 160'(rd_done), 160'(1'b0));
    chk("arst_dv", 160'(dout_valid), 160'(1'b0));
    chk("arst_isc", 160'(is_centroid), 160'(1'b0));
    chk("arst_valid", 160'(valid), 160'(32'd0));
    chk("arst_idx", 160'(dout_idx), 160'(5'd0));
    chk("arst_raddr", 160'(PFT_raddr), 160'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int b = 0; b < NB; b++) cnt_m[b] = 0;
    do_write(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
